// File: rtl/oled_seq_core.sv
// Instruction-driven SPI display sequencer: program memory, byte-slot decoder FSM
// and delay counter that gates the external program counter.
module oled_seq_core #(
   parameter int memBits      = 10,
   parameter int memAddrWidth = 16,
   parameter int memDepth     = 1024,
   parameter int dataBits     = 8,
   parameter int delayUnit    = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sclkPosEdge,
   input  logic                    writeEnable,
   input  logic [memAddrWidth-1:0] addr,
   input  logic [memBits-1:0]      dataIn,
   output logic [memBits-1:0]      dataOut,
   output logic                    cs,
   output logic                    dc,
   output logic [dataBits-1:0]     parallelData,
   output logic                    delayEn,
   output logic                    pcEn,
   output logic                    done
);

   localparam int IDX_W = (memDepth > 1) ? $clog2(memDepth) : 1;
   localparam int CNT_W = $clog2(((1 << dataBits) - 1) * delayUnit + 1);
   localparam logic [memAddrWidth-1:0] DEPTH_A = memAddrWidth'(memDepth);

   localparam logic [1:0] OP_CMD   = 2'b00;
   localparam logic [1:0] OP_DATA  = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DELAY, S_HALT} state_t;

   logic [memBits-1:0]  mem_q [memDepth];
   logic [memBits-1:0]  dataOut_q;
   logic                inRange;
   logic [IDX_W-1:0]    idx;

   state_t              state_q, state_d;
   logic                cs_q, cs_d;
   logic                dc_q, dc_d;
   logic [dataBits-1:0] pd_q, pd_d;
   logic                delayEn_q, delayEn_d;
   logic                done_q, done_d;
   logic [dataBits-1:0] dlyPay_q, dlyPay_d;
   logic [2:0]          bitCnt_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                boundary;
   logic                decode;
   logic [1:0]          opcode;
   logic [dataBits-1:0] payload;

   assign inRange = (addr < DEPTH_A);
   assign idx     = addr[IDX_W-1:0];

   // Out-of-range addresses neither write nor read back anything but zero.
   always_ff @(posedge clk) begin
      if (writeEnable && inRange) mem_q[idx] <= dataIn;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dataOut_q <= '0;
      else        dataOut_q <= inRange ? mem_q[idx] : '0;
   end

   assign opcode  = dataOut_q[memBits-1 -: 2];
   assign payload = dataOut_q[dataBits-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           bitCnt_q <= 3'd0;
      else if (sclkPosEdge) bitCnt_q <= bitCnt_q + 3'd1;
   end

   assign boundary = sclkPosEdge && (bitCnt_q == 3'd0);

   always_comb begin
      state_d   = state_q;
      cs_d      = cs_q;
      dc_d      = dc_q;
      pd_d      = pd_q;
      delayEn_d = 1'b0;
      done_d    = done_q;
      dlyPay_d  = dlyPay_q;
      decode    = 1'b0;
      case (state_q)
         S_IDLE, S_SEND: decode = boundary;
         S_DELAY:        decode = boundary && pcEn;
         default:        decode = 1'b0;
      endcase
      if (decode) begin
         case (opcode)
            OP_CMD, OP_DATA: begin
               state_d = S_SEND;
               cs_d    = 1'b0;
               dc_d    = (opcode == OP_DATA);
               pd_d    = payload;
            end
            OP_DELAY: begin
               state_d   = S_DELAY;
               cs_d      = 1'b1;
               delayEn_d = 1'b1;
               dlyPay_d  = payload;
            end
            default: begin
               state_d = S_HALT;
               cs_d    = 1'b1;
               done_d  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cs_q      <= 1'b1;
         dc_q      <= 1'b0;
         pd_q      <= '0;
         delayEn_q <= 1'b0;
         done_q    <= 1'b0;
         dlyPay_q  <= '0;
      end else begin
         state_q   <= state_d;
         cs_q      <= cs_d;
         dc_q      <= dc_d;
         pd_q      <= pd_d;
         delayEn_q <= delayEn_d;
         done_q    <= done_d;
         dlyPay_q  <= dlyPay_d;
      end
   end

   // Loaded one clk after the delayEn pulse, so pcEn drops exactly one clk later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt_q <= '0;
      else if (delayEn_q)        cnt_q <= CNT_W'(dlyPay_q) * CNT_W'(delayUnit);
      else if (cnt_q != '0)      cnt_q <= cnt_q - CNT_W'(1);
   end

   assign pcEn         = (cnt_q == '0) && (state_q != S_HALT);
   assign dataOut      = dataOut_q;
   assign cs           = cs_q;
   assign dc           = dc_q;
   assign parallelData = pd_q;
   assign delayEn      = delayEn_q;
   assign done         = done_q;

endmodule

// File: tb/tb_oled_seq_core.sv
// Directed bench for oled_seq_core: memory access, CMD/DATA slots, delays, halt, reset.
module tb_oled_seq_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclkPosEdge = 1'b0;
   logic        writeEnable = 1'b0;
   logic [15:0] addr = 16'd0;
   logic [9:0]  dataIn = 10'd0;
   logic [9:0]  dataOut;
   logic        cs, dc, delayEn, pcEn, done;
   logic [7:0]  parallelData;

   int n_cmp = 0;
   int n_bad = 0;
   int csHi = 0, deHi = 0, pcLo = 0;
   int csB, deB, pcB;

   oled_seq_core #(
      .memBits(10), .memAddrWidth(16), .memDepth(1024), .dataBits(8), .delayUnit(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sclkPosEdge(sclkPosEdge), .writeEnable(writeEnable),
      .addr(addr), .dataIn(dataIn), .dataOut(dataOut), .cs(cs), .dc(dc),
      .parallelData(parallelData), .delayEn(delayEn), .pcEn(pcEn), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cs)       csHi++;
      if (delayEn)  deHi++;
      if (!pcEn)    pcLo++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [9:0] d);
      addr = a;
      dataIn = d;
      writeEnable = 1'b1;
      tick();
      writeEnable = 1'b0;
   endtask

   task automatic strobe(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         sclkPosEdge = 1'b1;
         tick();
         sclkPosEdge = 1'b0;
         repeat (gap) tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      check("rst_cs",      32'(cs), 32'd1);
      check("rst_dc",      32'(dc), 32'd0);
      check("rst_pd",      32'(parallelData), 32'h0);
      check("rst_delayEn", 32'(delayEn), 32'd0);
      check("rst_pcEn",    32'(pcEn), 32'd1);
      check("rst_done",    32'(done), 32'd0);
      check("rst_dataOut", 32'(dataOut), 32'h0);
      rst_n = 1'b1;
      tick();

      wr(16'd0, 10'h0AE); wr(16'd1, 10'h0AF); wr(16'd2, 10'h155); wr(16'd3, 10'h202);
      wr(16'd4, 10'h0C3); wr(16'd5, 10'h200); wr(16'd6, 10'h13C); wr(16'd7, 10'h300);
      wr(16'd1024, 10'h3FF);
      addr = 16'd1024;
      tick();
      check("oob_read", 32'(dataOut), 32'h0);
      wr(16'd8, 10'h111);
      wr(16'd8, 10'h222);
      check("rdw_old", 32'(dataOut), 32'h111);
      tick();
      check("rdw_new", 32'(dataOut), 32'h222);
      addr = 16'd0;
      tick();
      check("rd_addr0", 32'(dataOut), 32'h0AE);
      check("idle_cs", 32'(cs), 32'd1);

      strobe(1, 1);
      check("cmd_cs", 32'(cs), 32'd0);
      check("cmd_dc", 32'(dc), 32'd0);
      check("cmd_pd", 32'(parallelData), 32'hAE);
      csB = csHi;
      addr = 16'd1;
      strobe(7, 1);
      check("cmd_hold_pd", 32'(parallelData), 32'hAE);
      strobe(1, 1);
      check("b2b_pd_af", 32'(parallelData), 32'hAF);
      check("b2b_dc_af", 32'(dc), 32'd0);
      addr = 16'd2;
      strobe(7, 1);
      strobe(1, 1);
      check("b2b_dc_55", 32'(dc), 32'd1);
      check("b2b_pd_55", 32'(parallelData), 32'h55);
      check("b2b_cs_low", 32'(csHi - csB), 32'd0);

      addr = 16'd3;
      strobe(7, 1);
      deB = deHi;
      pcB = pcLo;
      strobe(1, 0);
      check("dly_pulse", 32'(delayEn), 32'd1);
      check("dly_cs", 32'(cs), 32'd1);
      check("dly_pcEn_first", 32'(pcEn), 32'd1);
      addr = 16'd4;
      strobe(8, 0);
      check("dly_ignored_cs", 32'(cs), 32'd1);
      check("dly_pcEn_low", 32'(pcEn), 32'd0);
      repeat (4) tick();
      check("dly_pcEn_back", 32'(pcEn), 32'd1);
      check("dly_pulse_cnt", 32'(deHi - deB), 32'd1);
      check("dly_low_cnt", 32'(pcLo - pcB), 32'd8);
      strobe(7, 1);
      strobe(1, 1);
      check("post_dly_cs", 32'(cs), 32'd0);
      check("post_dly_dc", 32'(dc), 32'd0);
      check("post_dly_pd", 32'(parallelData), 32'hC3);

      addr = 16'd5;
      strobe(7, 1);
      deB = deHi;
      pcB = pcLo;
      strobe(1, 1);
      check("dly0_cs", 32'(cs), 32'd1);
      addr = 16'd6;
      strobe(7, 1);
      strobe(1, 1);
      check("dly0_next_cs", 32'(cs), 32'd0);
      check("dly0_next_dc", 32'(dc), 32'd1);
      check("dly0_next_pd", 32'(parallelData), 32'h3C);
      check("dly0_pcEn_low", 32'(pcLo - pcB), 32'd0);
      check("dly0_pulse_cnt", 32'(deHi - deB), 32'd1);

      addr = 16'd7;
      strobe(7, 1);
      strobe(1, 1);
      check("halt_done", 32'(done), 32'd1);
      check("halt_pcEn", 32'(pcEn), 32'd0);
      check("halt_cs", 32'(cs), 32'd1);
      addr = 16'd0;
      strobe(16, 1);
      check("halt_hold_done", 32'(done), 32'd1);
      check("halt_hold_cs", 32'(cs), 32'd1);
      check("halt_hold_dc", 32'(dc), 32'd1);
      check("halt_hold_pd", 32'(parallelData), 32'h3C);
      check("halt_hold_pcEn", 32'(pcEn), 32'd0);
      check("no_alias_addr0", 32'(dataOut), 32'h0AE);

      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_cs", 32'(cs), 32'd1);
      check("async_rst_dc", 32'(dc), 32'd0);
      check("async_rst_pd", 32'(parallelData), 32'h0);
      check("async_rst_pcEn", 32'(pcEn), 32'd1);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_dataOut", 32'(dataOut), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("after_rst_dataOut", 32'(dataOut), 32'h0AE);
      strobe(1, 1);
      check("after_rst_cs", 32'(cs), 32'd0);
      check("after_rst_pd", 32'(parallelData), 32'hAE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
